eco_patch_lut_bank: RTL and testbench

Run-time programmable successor to the fixed ECO patch netlist. NUM_TGT target nets are each driven by a selectable source:
- the original (unpatched) net,
- a constant 0 or 1,
- a 2^NUM_IN-entry lookup table over a shared patch-input vector.

Configuration goes into a shadow bank through a valid/ready handshake and is committed atomically, so targets never see a half-loaded patch. The block sits between the original logic cone and the target-net consumers.

---
 rtl/eco_patch_lut_bank.sv | 200 ++++++++++++++++++++
 tb/tb_eco_patch_lut_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/eco_patch_lut_bank.sv
// Run-time programmable ECO patch bank: per-target passthrough / LUT / constant source,
// loaded through a shadow bank and committed atomically. Optional: ECO_PATCH_PARITY_EN.
`timescale 1ns/1ps

module eco_patch_lut_bank #(
  parameter  int NUM_IN  = 4,
  parameter  int NUM_TGT = 2,
  parameter  int TGT_W   = 1,
  localparam int LUT_W   = 2 ** NUM_IN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IN-1:0]  in_vec,
  input  logic [NUM_TGT-1:0] orig_vec,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [TGT_W-1:0]   cfg_tgt,
  input  logic [1:0]         cfg_mode,
  input  logic [LUT_W-1:0]   cfg_lut,
  input  logic               cfg_commit,
  output logic               cfg_err,
  output logic [NUM_TGT-1:0] t_vec,
  output logic               patch_active
`ifdef ECO_PATCH_PARITY_EN
  ,
  output logic               parity_err
`endif
);

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_LUT  = 2'b01,
    MODE_ZERO = 2'b10,
    MODE_ONE  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  typedef struct packed {
    mode_e             mode;
    logic [LUT_W-1:0]  lut;
  } entry_t;

  state_e               state_q, state_d;
  entry_t               shadow_q [NUM_TGT];
  entry_t               shadow_d [NUM_TGT];
  entry_t               active_q [NUM_TGT];
  entry_t               active_d [NUM_TGT];
  logic                 cfg_err_q, cfg_err_d;
  logic [NUM_TGT-1:0]   t_vec_q, t_vec_d;
  logic                 patch_active_q, patch_active_d;
`ifdef ECO_PATCH_PARITY_EN
  logic [NUM_TGT-1:0]   shadow_par_q, shadow_par_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic                 commit_go;
  logic                 wr_fire;
  logic [NUM_TGT-1:0]   tgt_hit;
  logic                 any_patched;

  // ---------------------------------------------------------------------------
  // Control FSM: IDLE accepts writes and commit requests, COMMIT lasts one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d   = state_q;
    commit_go = 1'b0;
    cfg_ready = (state_q == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (cfg_commit) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit_go = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shadow bank writes and sticky out-of-range error.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_fire = cfg_valid & cfg_ready;
    for (int i = 0; i < NUM_TGT; i++) begin
      tgt_hit[i] = (cfg_tgt == TGT_W'(i));
    end
    cfg_err_d = cfg_err_q | (wr_fire & ~(|tgt_hit));
  end

  always_comb begin
    shadow_d = shadow_q;
`ifdef ECO_PATCH_PARITY_EN
    shadow_par_d = shadow_par_q;
`endif
    for (int i = 0; i < NUM_TGT; i++) begin
      if (wr_fire && tgt_hit[i]) begin
        shadow_d[i].mode = mode_e'(cfg_mode);
        shadow_d[i].lut  = cfg_lut;
`ifdef ECO_PATCH_PARITY_EN
        // Even parity: stored bit makes the total number of ones even.
        shadow_par_d[i] = ^{cfg_mode, cfg_lut};
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Atomic commit: whole shadow bank moves into the active bank on one edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    active_d = active_q;
`ifdef ECO_PATCH_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (commit_go) begin
      for (int i = 0; i < NUM_TGT; i++) begin
        active_d[i] = shadow_q[i];
`ifdef ECO_PATCH_PARITY_EN
        if ((^shadow_q[i]) != shadow_par_q[i]) begin
          active_d[i].mode = MODE_PASS;
          parity_err_d     = 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    any_patched = 1'b0;
    for (int i = 0; i < NUM_TGT; i++) begin
      any_patched = any_patched | (active_d[i].mode != MODE_PASS);
    end
    patch_active_d = commit_go ? any_patched : patch_active_q;
  end

  // ---------------------------------------------------------------------------
  // Target datapath: always driven from the active bank, never the shadow.
  // ---------------------------------------------------------------------------
  always_comb begin
    t_vec_d = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      case (active_q[i].mode)
        MODE_PASS: t_vec_d[i] = orig_vec[i];
        MODE_LUT:  t_vec_d[i] = active_q[i].lut[in_vec];
        MODE_ZERO: t_vec_d[i] = 1'b0;
        MODE_ONE:  t_vec_d[i] = 1'b1;
        default:   t_vec_d[i] = orig_vec[i];
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cfg_err_q      <= 1'b0;
      t_vec_q        <= '0;
      patch_active_q <= 1'b0;
      // NOTE: both banks are reset because their contents are visible through
      // t_vec and patch_active right after reset; a pending commit is dropped.
      for (int i = 0; i < NUM_TGT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
`ifdef ECO_PATCH_PARITY_EN
      shadow_par_q <= '0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q        <= state_d;
      cfg_err_q      <= cfg_err_d;
      t_vec_q        <= t_vec_d;
      patch_active_q <= patch_active_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
`ifdef ECO_PATCH_PARITY_EN
      shadow_par_q   <= shadow_par_d;
      parity_err_q   <= parity_err_d;
`endif
    end
  end

  assign cfg_err      = cfg_err_q;
  assign t_vec        = t_vec_q;
  assign patch_active = patch_active_q;
`ifdef ECO_PATCH_PARITY_EN
  assign parity_err   = parity_err_q;
`endif

endmodule

// File: tb/tb_eco_patch_lut_bank.sv
// Directed scoreboard bench for eco_patch_lut_bank: driver queues expected
// observations per cycle, a monitor pops and compares them.
`timescale 1ns/1ps

module tb_eco_patch_lut_bank;

  localparam int NUM_IN  = 4;
  localparam int NUM_TGT = 2;
  localparam int TGT_W   = 2;
  localparam int LUT_W   = 2 ** NUM_IN;

  logic               clk;
  logic               clk_en;
  logic               rst;
  logic [NUM_IN-1:0]  in_vec;
  logic [NUM_TGT-1:0] orig_vec;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [TGT_W-1:0]   cfg_tgt;
  logic [1:0]         cfg_mode;
  logic [LUT_W-1:0]   cfg_lut;
  logic               cfg_commit;
  logic               cfg_err;
  logic [NUM_TGT-1:0] t_vec;
  logic               patch_active;
`ifdef ECO_PATCH_PARITY_EN
  logic               parity_err;
`endif

  eco_patch_lut_bank #(
    .NUM_IN (NUM_IN),
    .NUM_TGT(NUM_TGT),
    .TGT_W  (TGT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vec      (in_vec),
    .orig_vec    (orig_vec),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_tgt     (cfg_tgt),
    .cfg_mode    (cfg_mode),
    .cfg_lut     (cfg_lut),
    .cfg_commit  (cfg_commit),
    .cfg_err     (cfg_err),
    .t_vec       (t_vec),
    .patch_active(patch_active)
`ifdef ECO_PATCH_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  // Expected observation; cyc < 0 means "check immediately on chk_ev".
  typedef struct {
    string      name;
    int         cyc;
    logic [1:0] t;
    logic       pa;
    logic       rdy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   tb_done;
  event chk_ev;

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] t, input logic pa,
                     input logic rdy, input logic err);
    exp_t e;
    e.name = name; e.cyc = cyc; e.t = t; e.pa = pa; e.rdy = rdy; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic chk_now(input string name, input logic [1:0] t, input logic pa,
                         input logic rdy, input logic err);
    exp_t e;
    e.name = name; e.cyc = -1; e.t = t; e.pa = pa; e.rdy = rdy; e.err = err;
    exp_q.push_back(e);
    ->chk_ev;
  endtask

  task automatic cfg_write(input logic [TGT_W-1:0] tgt, input logic [1:0] mode,
                           input logic [LUT_W-1:0] lut);
    cfg_valid = 1'b1;
    cfg_tgt   = tgt;
    cfg_mode  = mode;
    cfg_lut   = lut;
  endtask

  task automatic cfg_idle();
    cfg_valid = 1'b0;
    cfg_tgt   = '0;
    cfg_mode  = 2'b00;
    cfg_lut   = '0;
  endtask

  // Monitor: compares every queued expectation when its cycle is observed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0 && (exp_q[0].cyc < 0 || exp_q[0].cyc <= cyc)) begin
        e = exp_q.pop_front();
        n_checks++;
        if (e.cyc >= 0 && e.cyc < cyc) begin
          n_fail++;
          $display("FAIL %s: not observed in cycle %0d (now %0d)", e.name, e.cyc, cyc);
        end else if ({t_vec, patch_active, cfg_ready, cfg_err} !== {e.t, e.pa, e.rdy, e.err}) begin
          n_fail++;
          $display("FAIL %s: got t_vec=%b patch_active=%b cfg_ready=%b cfg_err=%b, want t_vec=%b patch_active=%b cfg_ready=%b cfg_err=%b",
                   e.name, t_vec, patch_active, cfg_ready, cfg_err, e.t, e.pa, e.rdy, e.err);
        end
      end
      if (tb_done) begin
        n_checks++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want end before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0; tb_done = 1'b0;
    clk_en = 1'b0; rst = 1'b0;
    in_vec = '0; orig_vec = '0; cfg_commit = 1'b0;
    cfg_idle();

    // 1. Asynchronous reset with the clock stopped.
    #2 rst = 1'b1;
    #1 chk_now("reset_async", 2'b00, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #5 clk_en = 1'b1;

    // 2. Passthrough with no configuration.
    orig_vec = 2'b10;
    step(); chk("pass_orig10", 2'b10, 1'b0, 1'b1, 1'b0);

    // 3. Load tgt0 = OR(in[0],in[1]) LUT, tgt1 = const0, then commit.
    in_vec = 4'b0001;
    cfg_write(2'd0, 2'b01, 16'hEEEE);
    step(); chk("shadow_w0_no_effect", 2'b10, 1'b0, 1'b1, 1'b0);
    cfg_write(2'd1, 2'b10, 16'h0000);
    step(); chk("shadow_w1_no_effect", 2'b10, 1'b0, 1'b1, 1'b0);
    cfg_idle();
    cfg_commit = 1'b1;
    step(); chk("load_e0_busy", 2'b10, 1'b0, 1'b0, 1'b0);
    cfg_commit = 1'b0;
    step(); chk("load_e1_old_cfg", 2'b10, 1'b1, 1'b1, 1'b0);
    step(); chk("load_e2_new_cfg", 2'b01, 1'b1, 1'b1, 1'b0);
    in_vec = 4'b0000;
    step(); chk("lut_in0", 2'b00, 1'b1, 1'b1, 1'b0);
    in_vec = 4'b0100;
    step(); chk("lut_in4", 2'b00, 1'b1, 1'b1, 1'b0);
    in_vec = 4'b0010;
    step(); chk("lut_in2", 2'b01, 1'b1, 1'b1, 1'b0);

    // 4. Write and commit on the same edge: the write is part of the commit.
    cfg_write(2'd1, 2'b11, 16'h0000);
    cfg_commit = 1'b1;
    step(); chk("simul_e0", 2'b01, 1'b1, 1'b0, 1'b0);
    cfg_idle();
    cfg_commit = 1'b0;
    step(); chk("simul_e1", 2'b01, 1'b1, 1'b1, 1'b0);
    step(); chk("simul_e2", 2'b11, 1'b1, 1'b1, 1'b0);

    // 5. Out-of-range target, then an uncommitted write stays invisible.
    cfg_write(2'd3, 2'b10, 16'h0000);
    step(); chk("bad_tgt_err", 2'b11, 1'b1, 1'b1, 1'b1);
    in_vec = 4'b0000;
    cfg_write(2'd0, 2'b11, 16'h0000);
    step(); chk("shadow_iso_a", 2'b10, 1'b1, 1'b1, 1'b1);
    cfg_idle();
    step(); chk("shadow_iso_b", 2'b10, 1'b1, 1'b1, 1'b1);
    cfg_commit = 1'b1;
    step(); chk("iso_commit_e0", 2'b10, 1'b1, 1'b0, 1'b1);
    cfg_commit = 1'b0;
    step(); chk("iso_commit_e1", 2'b10, 1'b1, 1'b1, 1'b1);
    step(); chk("iso_commit_e2", 2'b11, 1'b1, 1'b1, 1'b1);

    // 6. Reset while a commit is in flight.
    cfg_commit = 1'b1;
    step(); chk("commit_pending", 2'b11, 1'b1, 1'b0, 1'b1);
    cfg_commit = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_now("reset_mid_commit", 2'b00, 1'b0, 1'b1, 1'b0);
    #1 orig_vec = 2'b01;
    rst = 1'b0;
    step(); chk("post_rst_pass", 2'b01, 1'b0, 1'b1, 1'b0);
    step(); chk("commit_lost", 2'b01, 1'b0, 1'b1, 1'b0);
    orig_vec = 2'b10;
    step(); chk("post_rst_pass10", 2'b10, 1'b0, 1'b1, 1'b0);

    step();
    step();
    tb_done = 1'b1;
    ->chk_ev;
  end

endmodule
